// File: rtl/routing_calc_scheduler_pkg.sv
// Shared types and constants for the routing-calculation scheduler.
// Address and channel widths default to the router's flit format.
package routing_calc_scheduler_pkg;

    localparam int unsigned FLIT_SRC_WIDTH = 4;
    localparam int unsigned FLIT_DST_WIDTH = 4;
    localparam int unsigned CHANNELS       = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Index reported by the arbiter when nobody is requesting.
    localparam int unsigned choose_NONE = 0;

endpackage

// File: rtl/routing_calc_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after
// ptr, wrapping modulo P_PORTS.
module m_RRArbiter
    import routing_calc_scheduler_pkg::*;
#(
    parameter int unsigned P_PORTS = 7,
    parameter int unsigned IW      = (P_PORTS > 1) ? $clog2(P_PORTS) : 1
) (
    input  logic [P_PORTS-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [P_PORTS-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               valid
);

    int unsigned   pos;
    logic [IW-1:0] k;

    always_comb begin
        grant = '0;
        idx   = IW'(choose_NONE);
        valid = 1'b0;
        pos   = 0;
        k     = '0;
        for (int unsigned i = 0; i < P_PORTS; i++) begin
            pos = ptr + i;
            if (pos >= P_PORTS) pos = pos - P_PORTS;
            k = IW'(pos);
            if (!valid && req[k]) begin
                valid    = 1'b1;
                grant[k] = 1'b1;
                idx      = k;
            end
        end
    end

endmodule

// File: rtl/routing_calc_scheduler.sv
// Shares one combinational routing unit among P_PORTS head-flit requesters:
// round-robin pick, registered addresses, bounded wait, one-cycle done pulse.
module routing_calc_scheduler
    import routing_calc_scheduler_pkg::*;
#(
    parameter int unsigned P_PORTS     = 7,
    parameter int unsigned P_SRC_WIDTH = FLIT_SRC_WIDTH,
    parameter int unsigned P_DST_WIDTH = FLIT_DST_WIDTH,
    parameter int unsigned P_CHANNELS  = CHANNELS,
    parameter int unsigned P_MAX_WAIT  = 4
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [P_PORTS-1:0]             req_in,
    input  logic [P_PORTS*P_SRC_WIDTH-1:0] req_src_in,
    input  logic [P_PORTS*P_DST_WIDTH-1:0] req_dst_in,
    output logic                           rc_enable,
    output logic [P_SRC_WIDTH-1:0]         rc_src,
    output logic [P_DST_WIDTH-1:0]         rc_dst,
    input  logic                           rc_success,
    input  logic [P_CHANNELS-1:0]          rc_result,
    output logic [P_PORTS-1:0]             grant_out,
    output logic [P_PORTS-1:0]             done_out,
    output logic [P_CHANNELS-1:0]          result_out,
    output logic                           err_out,
    output logic                           busy_out
);

    localparam int unsigned IW = (P_PORTS > 1) ? $clog2(P_PORTS) : 1;
    localparam int unsigned CW = (P_MAX_WAIT > 1) ? $clog2(P_MAX_WAIT) : 1;

    state_t             state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      owner_idx;
    logic [CW-1:0]      wait_cnt;
    logic [P_PORTS-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_valid;

    m_RRArbiter #(
        .P_PORTS (P_PORTS),
        .IW      (IW)
    ) u_arb (
        .req   (req_in),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            ptr        <= '0;
            owner_idx  <= '0;
            wait_cnt   <= '0;
            rc_enable  <= 1'b0;
            rc_src     <= '0;
            rc_dst     <= '0;
            grant_out  <= '0;
            done_out   <= '0;
            result_out <= '0;
            err_out    <= 1'b0;
            busy_out   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        rc_src    <= req_src_in[arb_idx*P_SRC_WIDTH +: P_SRC_WIDTH];
                        rc_dst    <= req_dst_in[arb_idx*P_DST_WIDTH +: P_DST_WIDTH];
                        grant_out <= arb_grant;
                        owner_idx <= arb_idx;
                        wait_cnt  <= '0;
                        rc_enable <= 1'b1;
                        busy_out  <= 1'b1;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    if (rc_success) begin
                        result_out <= rc_result;
                        err_out    <= !$onehot(rc_result);
                        done_out   <= grant_out;
                        rc_enable  <= 1'b0;
                        state      <= RESP;
                    end else if (wait_cnt == CW'(P_MAX_WAIT - 1)) begin
                        // Abort: the unit never answered within the wait budget.
                        result_out <= '0;
                        err_out    <= 1'b1;
                        done_out   <= grant_out;
                        rc_enable  <= 1'b0;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    done_out   <= '0;
                    result_out <= '0;
                    err_out    <= 1'b0;
                    grant_out  <= '0;
                    busy_out   <= 1'b0;
                    ptr        <= (owner_idx == IW'(P_PORTS - 1)) ? '0 : owner_idx + 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_routing_calc_scheduler.sv
// Self-checking bench for routing_calc_scheduler: directed and randomized
// operations compared against a behavioural round-robin model.
module tb_routing_calc_scheduler;

    localparam int P  = 7;
    localparam int SW = 4;
    localparam int DW = 4;
    localparam int CH = 7;
    localparam int MW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [P-1:0]    req_in;
    logic [P*SW-1:0] req_src_in;
    logic [P*DW-1:0] req_dst_in;
    logic            rc_enable;
    logic [SW-1:0]   rc_src;
    logic [DW-1:0]   rc_dst;
    logic            rc_success;
    logic [CH-1:0]   rc_result;
    logic [P-1:0]    grant_out;
    logic [P-1:0]    done_out;
    logic [CH-1:0]   result_out;
    logic            err_out;
    logic            busy_out;

    routing_calc_scheduler #(
        .P_PORTS     (P),
        .P_SRC_WIDTH (SW),
        .P_DST_WIDTH (DW),
        .P_CHANNELS  (CH),
        .P_MAX_WAIT  (MW)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .req_in     (req_in),
        .req_src_in (req_src_in),
        .req_dst_in (req_dst_in),
        .rc_enable  (rc_enable),
        .rc_src     (rc_src),
        .rc_dst     (rc_dst),
        .rc_success (rc_success),
        .rc_result  (rc_result),
        .grant_out  (grant_out),
        .done_out   (done_out),
        .result_out (result_out),
        .err_out    (err_out),
        .busy_out   (busy_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int mptr  = 0;
    logic [SW-1:0] srcs [P];
    logic [DW-1:0] dsts [P];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_addrs();
        for (int i = 0; i < P; i++) begin
            srcs[i] = SW'($urandom);
            dsts[i] = DW'($urandom);
            req_src_in[i*SW +: SW] = srcs[i];
            req_dst_in[i*DW +: DW] = dsts[i];
        end
    endtask

    function automatic logic exp_err(input logic [CH-1:0] r);
        int n = 0;
        for (int i = 0; i < CH; i++) n += int'(r[i]);
        return n != 1;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_en"}, rc_enable, 0);
        chk({tag, "_src"}, rc_src, 0);
        chk({tag, "_dst"}, rc_dst, 0);
        chk({tag, "_grant"}, grant_out, 0);
        chk({tag, "_done"}, done_out, 0);
        chk({tag, "_result"}, result_out, 0);
        chk({tag, "_err"}, err_out, 0);
        chk({tag, "_busy"}, busy_out, 0);
    endtask

    // One full operation from an IDLE negedge; succ = CALC cycle on which the
    // unit succeeds (0 = never, forcing the timeout path).
    task automatic do_op(input logic [P-1:0] reqv, input int succ, input logic [CH-1:0] res);
        int w;
        int c;
        logic [SW-1:0] es;
        logic [DW-1:0] ed;
        logic [P-1:0]  oh;
        new_addrs();
        req_in     = reqv;
        rc_success = 1'b0;
        chk("idle_busy", busy_out, 0);
        chk("idle_done", done_out, 0);
        w = 0;
        for (int i = P - 1; i >= 0; i--)
            if (reqv[(mptr + i) % P]) w = (mptr + i) % P;
        es = srcs[w];
        ed = dsts[w];
        oh = P'(1) << w;
        @(negedge clk);
        for (c = 1; c <= MW; c++) begin
            chk("calc_en", rc_enable, 1);
            chk("calc_grant", grant_out, oh);
            chk("calc_src", rc_src, es);
            chk("calc_dst", rc_dst, ed);
            chk("calc_done", done_out, 0);
            new_addrs();
            rc_success = (c == succ);
            rc_result  = (c == succ) ? res : CH'($urandom);
            @(negedge clk);
            if (c == succ || c == MW) break;
        end
        rc_success = 1'b0;
        chk("resp_done", done_out, oh);
        chk("resp_result", result_out, (succ >= 1) ? res : '0);
        chk("resp_err", err_out, (succ >= 1) ? exp_err(res) : 1'b1);
        chk("resp_en", rc_enable, 0);
        chk("resp_busy", busy_out, 1);
        req_in = reqv & ~oh;
        mptr = (w + 1) % P;
        @(negedge clk);
        chk("post_done", done_out, 0);
        chk("post_result", result_out, 0);
        chk("post_busy", busy_out, 0);
    endtask

    initial begin
        rst        = 1'b1;
        req_in     = '0;
        req_src_in = '0;
        req_dst_in = '0;
        rc_success = 1'b0;
        rc_result  = '0;
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        do_op(7'b0000100, 1, 7'b0000001);

        for (int k = 0; k < 8; k++)
            do_op(7'h7F, 1, CH'(1) << $urandom_range(0, CH - 1));

        do_op(7'b0010000, 1, 7'b0000010);
        do_op(7'b0001010, 1, 7'b0000100);
        do_op(7'b0001000, 1, 7'b0001000);

        do_op(7'b0100001, 0, 7'b1111111);
        do_op(7'b0000001, 1, 7'b0000110);
        do_op(7'b1000000, 1, 7'b0000000);
        do_op(7'b0000010, MW, 7'b0100000);

        for (int k = 0; k < 20; k++) begin
            logic [CH-1:0] r;
            if ($urandom_range(0, 1) == 1) r = CH'(1) << $urandom_range(0, CH - 1);
            else r = CH'($urandom);
            do_op(P'($urandom_range(1, (1 << P) - 1)), $urandom_range(0, MW), r);
        end

        // Drive the pointer to 2, start an operation, then reset mid-CALC.
        do_op(7'b0000010, 1, 7'b0000001);
        new_addrs();
        req_in = 7'b0001010;
        @(negedge clk);
        chk("pre_rst_grant", grant_out, 7'b0001000);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        @(negedge clk);
        check_zero("held_rst");
        rst  = 1'b0;
        mptr = 0;
        do_op(7'b0001010, 1, 7'b0000001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
